// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the RV32I load/store unit.
// Contents:
//   F3_*           funct3 encodings of the supported load/store widths
//   lsu_state_e    2-bit FSM state encoding
//   lane_strobe    byte-lane strobe pattern for a width and address offset
//   is_illegal     funct3 legality check (stores have no unsigned forms)
//   is_misaligned  natural-alignment check for halfword and word accesses
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    // The width is taken from funct3[1:0], so BU/HU share B/H lane patterns.
    function automatic logic [3:0] lane_strobe(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic is_illegal(input logic [2:0] f3, input logic store);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (store && f3[2]);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory port of the load/store unit: single outstanding valid/ready
// request with byte strobes.
// Signals:
//   mem_req    request valid (driven by the LSU)
//   mem_we     write enable
//   mem_addr   word-aligned address
//   mem_wdata  store data replicated into byte lanes
//   mem_wstrb  byte-lane strobes (0000 on loads)
//   mem_ready  memory accepted / read data valid this cycle
//   mem_rdata  read word, valid with mem_ready
// Modports: master = LSU side, slave = memory side.
interface load_store_unit_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/load_store_unit_load_align.sv
// Combinational load extractor: selects the byte/halfword lane addressed by
// addr[1:0] out of the read word and sign- or zero-extends it to 32 bits.
// Ports:
//   mem_rdata  in  32  read word from memory
//   addr       in  2   byte offset within the word
//   funct3     in  3   load width/sign encoding
//   result     out 32  extended load value
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic        [7:0]  byte_lane;
    logic        [15:0] half_lane;
    logic signed [31:0] byte_sext;
    logic signed [31:0] half_sext;

    always_comb begin
        case (addr)
            2'd0:    byte_lane = mem_rdata[7:0];
            2'd1:    byte_lane = mem_rdata[15:8];
            2'd2:    byte_lane = mem_rdata[23:16];
            default: byte_lane = mem_rdata[31:24];
        endcase
        // Halfword loads are only issued when aligned, so addr[1] picks the half.
        half_lane = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        byte_sext = 32'(signed'(byte_lane));
        half_sext = 32'(signed'(half_lane));

        case (funct3)
            F3_B:    result = $unsigned(byte_sext);
            F3_H:    result = $unsigned(half_sext);
            F3_BU:   result = {24'd0, byte_lane};
            F3_HU:   result = {16'd0, half_lane};
            default: result = mem_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store engine. Accepts an effective address, funct3 and store
// data, runs one request on the data-memory port and returns an extended
// load result with a one-cycle done pulse. Illegal funct3 and misaligned
// accesses complete immediately without touching memory; an unanswered
// request is abandoned after MAX_WAIT cycles (0 disables the timeout).
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              command strobe, only honoured while idle
//   is_store, funct3   access type and width
//   addr, wdata        effective address and store data
//   busy, done         status / completion pulse
//   rdata              load result, held until the next completing load
//   misaligned         alignment fault, valid with done
//   bus_err            timeout or illegal funct3, valid with done
//   mem                data-memory port (master side)
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        bus_err,
    load_store_unit_if.master mem
);

    localparam int unsigned CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    lsu_state_e state, state_next;

    logic             is_store_q;
    logic [2:0]       funct3_q;
    logic [1:0]       off_q;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_inc;
    logic             fault_illegal;
    logic             fault_misaligned;
    logic             fault;
    logic             timeout;
    logic [31:0]      load_result;

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    assign fault_illegal    = is_illegal(funct3, is_store);
    assign fault_misaligned = is_misaligned(funct3, addr[1:0]);
    assign fault            = fault_illegal || fault_misaligned;

    assign wait_cnt_inc = wait_cnt + 1'b1;
    // Fires on the cycle that would bring the counter to MAX_WAIT; the caller
    // only acts on it when mem_ready is low, so a last-cycle answer still wins.
    assign timeout      = (MAX_WAIT != 0) && (wait_cnt_inc == CNT_W'(MAX_WAIT));

    lsu_load_align u_align (
        .mem_rdata (mem.mem_rdata),
        .addr      (off_q),
        .funct3    (funct3_q),
        .result    (load_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        done        = 1'b0;
        mem.mem_req = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = fault ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                busy        = 1'b1;
                mem.mem_req = 1'b1;
                if (mem.mem_ready || timeout) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_store_q    <= 1'b0;
            funct3_q      <= 3'd0;
            off_q         <= 2'd0;
            wait_cnt      <= '0;
            rdata         <= 32'd0;
            misaligned    <= 1'b0;
            bus_err       <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 32'd0;
            mem.mem_wdata <= 32'd0;
            mem.mem_wstrb <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        is_store_q    <= is_store;
                        funct3_q      <= funct3;
                        off_q         <= addr[1:0];
                        wait_cnt      <= '0;
                        bus_err       <= fault_illegal;
                        misaligned    <= fault_misaligned && !fault_illegal;
                        mem.mem_we    <= is_store && !fault;
                        mem.mem_addr  <= {addr[31:2], 2'b00};
                        mem.mem_wdata <= store_lanes(funct3, wdata);
                        mem.mem_wstrb <= (is_store && !fault) ? lane_strobe(funct3, addr[1:0]) : 4'b0000;
                    end
                end
                ST_REQ: begin
                    if (mem.mem_ready) begin
                        mem.mem_we <= 1'b0;
                        if (!is_store_q) begin
                            rdata <= load_result;
                        end
                    end else begin
                        wait_cnt <= wait_cnt_inc;
                        if (timeout) begin
                            bus_err    <= 1'b1;
                            mem.mem_we <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        misaligned;
    logic        bus_err;

    load_store_unit_if mem_bus ();

    load_store_unit #(.MAX_WAIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .mem        (mem_bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        err;
        int          start_cyc;
        int          lat;
        int          nreq;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string why);
        n_cmp++;
        n_err++;
        $display("FAIL %s: %s", name, why);
    endtask

    // Memory model: answers after wait_n request cycles with resp_data.
    int          wait_n = 0;
    logic [31:0] resp_data = 32'd0;
    initial begin : responder
        int seen;
        seen = 0;
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (mem_bus.mem_req === 1'b1) begin
                if (seen == wait_n) begin
                    mem_bus.mem_ready = 1'b1;
                    mem_bus.mem_rdata = resp_data;
                end else begin
                    mem_bus.mem_ready = 1'b0;
                    mem_bus.mem_rdata = 32'd0;
                end
                seen++;
            end else begin
                mem_bus.mem_ready = 1'b0;
                mem_bus.mem_rdata = 32'd0;
                seen = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on each new request and on each done pulse.
    initial begin : monitor
        req_t r;
        rsp_t e;
        int   nreq_seen;
        logic prev_req;
        nreq_seen = 0;
        prev_req  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                nreq_seen = 0;
                prev_req  = 1'b0;
            end else begin
                if (mem_bus.mem_req === 1'b1) begin
                    if (!prev_req) begin
                        if (req_q.size() == 0) begin
                            fail("req_unexpected", $sformatf("mem_req at cycle %0d with nothing expected", cyc));
                        end else begin
                            r = req_q.pop_front();
                            chk("mem_addr", mem_bus.mem_addr, r.addr);
                            chk("mem_we", 32'(mem_bus.mem_we), 32'(r.we));
                            chk("mem_wstrb", 32'(mem_bus.mem_wstrb), 32'(r.wstrb));
                            if (r.we) chk("mem_wdata", mem_bus.mem_wdata, r.wdata);
                        end
                    end
                    nreq_seen++;
                end
                prev_req = mem_bus.mem_req;
                if (done === 1'b1) begin
                    if (rsp_q.size() == 0) begin
                        fail("done_unexpected", $sformatf("done at cycle %0d with nothing expected", cyc));
                    end else begin
                        e = rsp_q.pop_front();
                        chk("rdata", rdata, e.rdata);
                        chk("misaligned", 32'(misaligned), 32'(e.mis));
                        chk("bus_err", 32'(bus_err), 32'(e.err));
                        chk("done_latency", 32'(cyc - e.start_cyc), 32'(e.lat));
                        chk("req_cycles", 32'(nreq_seen), 32'(e.nreq));
                    end
                    nreq_seen = 0;
                end
            end
        end
    end

    // Issue one command and wait (bounded) for the unit to return to idle.
    task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input int wt, input logic [31:0] word,
                       input logic exp_req, input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                       input logic [31:0] exp_wd, input logic [31:0] exp_rdata,
                       input logic exp_mis, input logic exp_err, input int lat, input int nreq);
        int i;
        @(negedge clk);
        is_store  = st;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        wait_n    = wt;
        resp_data = word;
        if (exp_req) req_q.push_back('{exp_addr, exp_wd, st, exp_strb});
        rsp_q.push_back('{exp_rdata, exp_mis, exp_err, cyc, lat, nreq});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        i = 0;
        while (busy !== 1'b0 && i < 50) begin
            @(negedge clk);
            i++;
        end
        if (busy !== 1'b0) fail("busy_timeout", "unit did not return to idle within 50 cycles");
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_mem_req"}, 32'(mem_bus.mem_req), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_bus.mem_we), 32'd0);
        chk({tag, "_mem_addr"}, mem_bus.mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_bus.mem_wdata, 32'd0);
        chk({tag, "_mem_wstrb"}, 32'(mem_bus.mem_wstrb), 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_misaligned"}, 32'(misaligned), 32'd0);
        chk({tag, "_bus_err"}, 32'(bus_err), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        repeat (2) @(negedge clk);
        chk_reset_values("reset");
        rst = 1'b0;

        // Loads: word, then byte/half lane selection and extension.
        //   st    f3     addr         wdata        wt  word          req   maddr        strb   mwdata       rdata         mis   err   lat nreq
        run(1'b0, F3_W,  32'h100, 32'h0,        2, 32'hDEADBEEF, 1'b1, 32'h100, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 4, 3);
        run(1'b0, F3_B,  32'h103, 32'h0,        0, 32'h80FF0000, 1'b1, 32'h100, 4'h0, 32'h0,        32'hFFFFFF80, 1'b0, 1'b0, 2, 1);
        run(1'b0, F3_BU, 32'h103, 32'h0,        0, 32'h80FF0000, 1'b1, 32'h100, 4'h0, 32'h0,        32'h00000080, 1'b0, 1'b0, 2, 1);
        run(1'b0, F3_HU, 32'h102, 32'h0,        0, 32'h80FF0000, 1'b1, 32'h100, 4'h0, 32'h0,        32'h000080FF, 1'b0, 1'b0, 2, 1);
        run(1'b0, F3_H,  32'h102, 32'h0,        0, 32'h80FF0000, 1'b1, 32'h100, 4'h0, 32'h0,        32'hFFFF80FF, 1'b0, 1'b0, 2, 1);
        run(1'b0, F3_B,  32'h101, 32'h0,        0, 32'h00007F00, 1'b1, 32'h100, 4'h0, 32'h0,        32'h0000007F, 1'b0, 1'b0, 2, 1);

        // Stores: lanes replicated, strobes shifted, rdata untouched.
        run(1'b1, F3_B,  32'h21,  32'h12345678, 1, 32'h0,        1'b1, 32'h20,  4'h2, 32'h78787878, 32'h0000007F, 1'b0, 1'b0, 3, 2);
        run(1'b1, F3_H,  32'h22,  32'h12345678, 0, 32'h0,        1'b1, 32'h20,  4'hC, 32'h56785678, 32'h0000007F, 1'b0, 1'b0, 2, 1);
        run(1'b1, F3_W,  32'h24,  32'hCAFEF00D, 0, 32'h0,        1'b1, 32'h24,  4'hF, 32'hCAFEF00D, 32'h0000007F, 1'b0, 1'b0, 2, 1);

        // Faults: no request, done in cycle 1; illegal beats misaligned.
        run(1'b0, F3_W,  32'h102, 32'h0,        0, 32'h0,        1'b0, 32'h0,   4'h0, 32'h0,        32'h0000007F, 1'b1, 1'b0, 1, 0);
        run(1'b1, F3_H,  32'h101, 32'h0,        0, 32'h0,        1'b0, 32'h0,   4'h0, 32'h0,        32'h0000007F, 1'b1, 1'b0, 1, 0);
        run(1'b0, 3'b011, 32'h100, 32'h0,       0, 32'h0,        1'b0, 32'h0,   4'h0, 32'h0,        32'h0000007F, 1'b0, 1'b1, 1, 0);
        run(1'b1, F3_BU, 32'h100, 32'h0,        0, 32'h0,        1'b0, 32'h0,   4'h0, 32'h0,        32'h0000007F, 1'b0, 1'b1, 1, 0);
        run(1'b0, 3'b110, 32'h102, 32'h0,       0, 32'h0,        1'b0, 32'h0,   4'h0, 32'h0,        32'h0000007F, 1'b0, 1'b1, 1, 0);
        run(1'b1, F3_HU, 32'h101, 32'h0,        0, 32'h0,        1'b0, 32'h0,   4'h0, 32'h0,        32'h0000007F, 1'b0, 1'b1, 1, 0);

        // Timeout with MAX_WAIT=4, recovery, then an answer on the limit cycle.
        run(1'b0, F3_W,  32'h200, 32'h0,     1000, 32'h0,        1'b1, 32'h200, 4'h0, 32'h0,        32'h0000007F, 1'b0, 1'b1, 5, 4);
        run(1'b0, F3_W,  32'h204, 32'h0,        0, 32'h11223344, 1'b1, 32'h204, 4'h0, 32'h0,        32'h11223344, 1'b0, 1'b0, 2, 1);
        run(1'b0, F3_W,  32'h300, 32'h0,        3, 32'hA5A50F0F, 1'b1, 32'h300, 4'h0, 32'h0,        32'hA5A50F0F, 1'b0, 1'b0, 5, 4);

        // Reset in REQ after a start issued while busy.
        @(negedge clk);
        is_store = 1'b0;
        funct3   = F3_W;
        addr     = 32'h400;
        wait_n   = 1000;
        req_q.push_back('{32'h400, 32'h0, 1'b0, 4'h0});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        is_store = 1'b1;
        addr     = 32'h500;
        wdata    = 32'hFFFFFFFF;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_addr", mem_bus.mem_addr, 32'h400);
        chk("busy_start_we", 32'(mem_bus.mem_we), 32'd0);
        chk("busy_start_req", 32'(mem_bus.mem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_values("mid_rst");
        repeat (6) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_req", 32'(mem_bus.mem_req), 32'd0);

        // Unit works again after the abort; rdata restarted from zero.
        run(1'b0, F3_BU, 32'h2,   32'h0,        0, 32'h00C30000, 1'b1, 32'h0,   4'h0, 32'h0,        32'h000000C3, 1'b0, 1'b0, 2, 1);

        repeat (2) @(negedge clk);
        chk("req_q_drained", 32'(req_q.size()), 32'd0);
        chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
